// File: rtl/atomik_video_streaming_delta_mc_if.sv
// Command/response bus for the multi-channel delta-state engine.
// master = command source (stream parser), slave = the engine.
interface atomik_video_streaming_delta_mc_if #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_CH     = 4,
  parameter int HIST_DEPTH = 64
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(HIST_DEPTH + 1);

  // Handshake: a transfer happens on a rising clk edge where valid && ready;
  // valid-side signals hold steady until that edge, ready may change freely.
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [CH_W-1:0]       cmd_ch;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0]      cmd_count;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [CH_W-1:0]       rsp_ch;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_data, cmd_count, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ch, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_data, cmd_count, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ch, rsp_err
  );
endinterface

// File: rtl/atomik_video_streaming_delta_mc.sv
// Multi-channel delta-state engine: per-channel {initial, accumulator} pairs with
// circular delta history, multi-step rollback, CLEAR and error reporting.
module atomik_video_streaming_delta_mc #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_CH     = 4,
  parameter int HIST_DEPTH = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  atomik_video_streaming_delta_mc_if.slave  bus,
  output logic [NUM_CH-1:0]                 acc_zero,
  output logic [NUM_CH-1:0]                 hist_full,
  output logic [1:0]                        state_dbg
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(HIST_DEPTH + 1);
  localparam int PTR_W = $clog2(HIST_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROLL = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ACCUM = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_ROLL  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] init_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] init_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] acc_q   [NUM_CH];
  logic [DATA_WIDTH-1:0] acc_d   [NUM_CH];
  logic [PTR_W-1:0]      head_q  [NUM_CH];
  logic [PTR_W-1:0]      head_d  [NUM_CH];
  logic [CNT_W-1:0]      count_q [NUM_CH];
  logic [CNT_W-1:0]      count_d [NUM_CH];
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CH_W-1:0]       rsp_ch_q, rsp_ch_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [NUM_CH-1:0]     acc_zero_q, acc_zero_d;
  logic [NUM_CH-1:0]     hist_full_q, hist_full_d;

  // History is addressed {ch, ptr}; rows above NUM_CH-1 exist but are never written.
  logic [DATA_WIDTH-1:0] hist_mem [(1 << CH_W) * HIST_DEPTH];
  logic                  hist_we;
  logic [CH_W+PTR_W-1:0] hist_wa;
  logic [DATA_WIDTH-1:0] hist_wd;

  logic                  ch_ok;
  logic [PTR_W-1:0]      roll_ptr;
  logic [DATA_WIDTH-1:0] roll_delta;

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    acc_d      = acc_q;
    head_d     = head_q;
    count_d    = count_q;
    rem_d      = rem_q;
    cur_ch_d   = cur_ch_q;
    rsp_data_d = rsp_data_q;
    rsp_ch_d   = rsp_ch_q;
    rsp_err_d  = rsp_err_q;
    hist_we    = 1'b0;
    hist_wa    = '0;
    hist_wd    = '0;
    ch_ok      = (int'(bus.cmd_ch) < NUM_CH);
    roll_ptr   = head_q[cur_ch_q] - PTR_W'(1);
    roll_delta = hist_mem[{cur_ch_q, roll_ptr}];

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cur_ch_d  = bus.cmd_ch;
          rsp_ch_d  = bus.cmd_ch;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
          if (!ch_ok || bus.cmd_op > OP_CLEAR) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            case (bus.cmd_op)
              OP_LOAD: begin
                init_d[bus.cmd_ch]  = bus.cmd_data;
                acc_d[bus.cmd_ch]   = '0;
                head_d[bus.cmd_ch]  = '0;
                count_d[bus.cmd_ch] = '0;
              end
              OP_ACCUM: begin
                acc_d[bus.cmd_ch]  = acc_q[bus.cmd_ch] ^ bus.cmd_data;
                hist_we            = 1'b1;
                hist_wa            = {bus.cmd_ch, head_q[bus.cmd_ch]};
                hist_wd            = bus.cmd_data;
                head_d[bus.cmd_ch] = head_q[bus.cmd_ch] + PTR_W'(1);
                if (count_q[bus.cmd_ch] != CNT_W'(HIST_DEPTH))
                  count_d[bus.cmd_ch] = count_q[bus.cmd_ch] + CNT_W'(1);
              end
              OP_CLEAR: begin
                acc_d[bus.cmd_ch]   = '0;
                head_d[bus.cmd_ch]  = '0;
                count_d[bus.cmd_ch] = '0;
              end
              OP_ROLL: begin
                // Asking for more steps than history holds rolls back what exists and flags it.
                if (bus.cmd_count > count_q[bus.cmd_ch]) begin
                  rem_d     = count_q[bus.cmd_ch];
                  rsp_err_d = 1'b1;
                end else begin
                  rem_d = bus.cmd_count;
                end
                if (rem_d != '0) state_d = ST_ROLL;
              end
              default: ;
            endcase
            rsp_data_d = init_d[bus.cmd_ch] ^ acc_d[bus.cmd_ch];
          end
        end
      end
      ST_ROLL: begin
        acc_d[cur_ch_q]   = acc_q[cur_ch_q] ^ roll_delta;
        head_d[cur_ch_q]  = roll_ptr;
        count_d[cur_ch_q] = count_q[cur_ch_q] - CNT_W'(1);
        rem_d             = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d    = ST_RESP;
          rsp_data_d = init_q[cur_ch_q] ^ acc_d[cur_ch_q];
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      acc_zero_d[i]  = (acc_d[i] == '0);
      hist_full_d[i] = (count_d[i] == CNT_W'(HIST_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      cur_ch_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ch_q    <= '0;
      rsp_err_q   <= 1'b0;
      acc_zero_q  <= '1;
      hist_full_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        init_q[i]  <= '0;
        acc_q[i]   <= '0;
        head_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cur_ch_q    <= cur_ch_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_err_q   <= rsp_err_d;
      acc_zero_q  <= acc_zero_d;
      hist_full_q <= hist_full_d;
      init_q      <= init_d;
      acc_q       <= acc_d;
      head_q      <= head_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hist_we && rst_n) hist_mem[hist_wa] <= hist_wd;
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ch    = rsp_ch_q;
  assign bus.rsp_err   = rsp_err_q;
  assign acc_zero      = acc_zero_q;
  assign hist_full     = hist_full_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_atomik_video_streaming_delta_mc.sv
// Directed scoreboard bench for atomik_video_streaming_delta_mc
// (DATA_WIDTH=16, NUM_CH=3, HIST_DEPTH=4).
module tb_atomik_video_streaming_delta_mc;
  localparam int DW    = 16;
  localparam int NCH   = 3;
  localparam int HD    = 4;
  localparam int CH_W  = 2;
  localparam int CNT_W = 3;
  localparam int RW    = DW + CH_W + 1;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ACCUM = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_ROLL  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  atomik_video_streaming_delta_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .HIST_DEPTH(HD)) bus ();
  logic [NCH-1:0] acc_zero;
  logic [NCH-1:0] hist_full;
  logic [1:0]     state_dbg;

  atomik_video_streaming_delta_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .HIST_DEPTH(HD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .acc_zero  (acc_zero),
    .hist_full (hist_full),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one pop per completed response handshake
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", exp_q.size(), 1);
      end else begin
        check("rsp {data,ch,err}", {bus.rsp_data, bus.rsp_ch, bus.rsp_err}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [2:0] op, input logic [CH_W-1:0] ch,
                       input logic [DW-1:0] data, input logic [CNT_W-1:0] cnt);
    int tmo;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_ch    = ch;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    bus.cmd_valid = 1'b1;
    tmo = 0;
    while (!bus.cmd_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) check("cmd_ready_timeout", tmo, 0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid || lat > 40) break;
      lat++;
    end
  endtask

  task automatic send(input string name, input logic [2:0] op, input logic [CH_W-1:0] ch,
                      input logic [DW-1:0] data, input logic [CNT_W-1:0] cnt,
                      input logic [DW-1:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    exp_q.push_back({exp_data, ch, exp_err});
    issue(op, ch, data, cnt);
    wait_rsp(lat);
    check({name, " latency"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_ch    = '0;
    bus.cmd_data  = '0;
    bus.cmd_count = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset cmd_ready", bus.cmd_ready, 1);
    check("reset rsp_data", bus.rsp_data, 0);
    check("reset rsp_err", bus.rsp_err, 0);
    check("reset acc_zero", acc_zero, 3'b111);
    check("reset hist_full", hist_full, 3'b000);
    check("reset state", state_dbg, 0);

    // 1: load / accumulate / read
    send("load ch0", OP_LOAD, 0, 16'h1234, 0, 16'h1234, 0, 1);
    send("accum ch0", OP_ACCUM, 0, 16'h00FF, 0, 16'h12CB, 0, 1);
    send("read ch0", OP_READ, 0, 16'h0000, 0, 16'h12CB, 0, 1);
    check("acc_zero after ch0 accum", acc_zero, 3'b110);

    // 2: history overflow then full rollback
    send("accum ch1 a", OP_ACCUM, 1, 16'h0001, 0, 16'h0001, 0, 1);
    send("accum ch1 b", OP_ACCUM, 1, 16'h0002, 0, 16'h0003, 0, 1);
    send("accum ch1 c", OP_ACCUM, 1, 16'h0004, 0, 16'h0007, 0, 1);
    send("accum ch1 d", OP_ACCUM, 1, 16'h0008, 0, 16'h000F, 0, 1);
    send("accum ch1 e", OP_ACCUM, 1, 16'h0010, 0, 16'h001F, 0, 1);
    check("hist_full after overflow", hist_full, 3'b010);
    send("rollback ch1 n4", OP_ROLL, 1, 16'h0000, 4, 16'h0001, 0, 5);
    check("hist_full after rollback", hist_full, 3'b000);

    // 3: over-long rollback and zero-step rollback
    send("load ch2", OP_LOAD, 2, 16'h5A5A, 0, 16'h5A5A, 0, 1);
    send("accum ch2 a", OP_ACCUM, 2, 16'h0F0F, 0, 16'h5555, 0, 1);
    send("accum ch2 b", OP_ACCUM, 2, 16'h00F0, 0, 16'h55A5, 0, 1);
    send("rollback ch2 n3", OP_ROLL, 2, 16'h0000, 3, 16'h5A5A, 1, 3);
    check("acc_zero after ch2 rollback", acc_zero, 3'b100);
    send("rollback ch2 n0", OP_ROLL, 2, 16'h0000, 0, 16'h5A5A, 0, 1);

    // 4: isolation, clear, illegal inputs
    send("read ch1 before", OP_READ, 1, 16'h0000, 0, 16'h0001, 0, 1);
    send("accum ch0 aaaa", OP_ACCUM, 0, 16'hAAAA, 0, 16'hB861, 0, 1);
    send("read ch1 after", OP_READ, 1, 16'h0000, 0, 16'h0001, 0, 1);
    send("clear ch0", OP_CLEAR, 0, 16'h0000, 0, 16'h1234, 0, 1);
    send("read ch0 cleared", OP_READ, 0, 16'h0000, 0, 16'h1234, 0, 1);
    send("bad channel", OP_READ, 3, 16'h0000, 0, 16'h0000, 1, 1);
    send("bad op", 3'd6, 0, 16'hFFFF, 0, 16'h0000, 1, 1);
    send("read ch0 post bad", OP_READ, 0, 16'h0000, 0, 16'h1234, 0, 1);
    check("acc_zero after clear", acc_zero, 3'b101);

    // 5: backpressure
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    exp_q.push_back({16'h1234, 2'd0, 1'b0});
    issue(OP_READ, 0, 16'h0000, 0);
    wait_rsp(lat);
    check("backpressure latency", lat, 1);
    bus.cmd_op    = OP_ACCUM;
    bus.cmd_ch    = 0;
    bus.cmd_data  = 16'hFFFF;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp rsp_valid held", bus.rsp_valid, 1);
      check("bp rsp_data held", bus.rsp_data, 16'h1234);
      check("bp cmd_ready low", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    send("read ch0 after bp", OP_READ, 0, 16'h0000, 0, 16'h1234, 0, 1);

    // 6: reset during rollback
    send("accum ch1 f", OP_ACCUM, 1, 16'h0100, 0, 16'h0101, 0, 1);
    send("accum ch1 g", OP_ACCUM, 1, 16'h0200, 0, 16'h0301, 0, 1);
    send("accum ch1 h", OP_ACCUM, 1, 16'h0400, 0, 16'h0701, 0, 1);
    send("accum ch1 i", OP_ACCUM, 1, 16'h0800, 0, 16'h0F01, 0, 1);
    check("hist_full before reset", hist_full, 3'b010);
    issue(OP_ROLL, 1, 16'h0000, 4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no rsp after reset", bus.rsp_valid, 0);
    end
    check("acc_zero after reset", acc_zero, 3'b111);
    check("hist_full after reset", hist_full, 3'b000);
    send("read ch1 after reset", OP_READ, 1, 16'h0000, 0, 16'h0000, 0, 1);
    send("read ch0 after reset", OP_READ, 0, 16'h0000, 0, 16'h0000, 0, 1);

    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
